proc_feeder: RTL and testbench

Instruction sequencer that drives the processor core's instruction port: it holds a small loadable program memory, presents each instruction word on `DIN` with a one-cycle `Run` pulse, supplies the immediate word for `mvi`, waits for `Done`, and advances its program counter. It sits between the test/boot loader and the processor, on the opposite side of the `DIN`/`Run`/`Done` handshake. A watchdog flags a core that never returns `Done`.

---
 rtl/proc_feeder.sv | 141 ++++++++++++++
 tb/tb_proc_feeder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_feeder.sv
// rtl/proc_feeder.sv - program-memory instruction sequencer for the core DIN/Run/Done port
//
// Purpose: holds a loadable 2^AW x 16 program memory. Issues each instruction
// on DIN with a one-cycle Run strobe. Keeps the mvi immediate on DIN while
// waiting for Done, then advances PC. A watchdog moves to an error state when
// the core never answers.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Start               begin execution at address 0 (IDLE/HALT/ERR only)
//   LdEn/LdAddr/LdData  program memory write port (IDLE/HALT/ERR only)
//   ProgLen             program length in words, 0..2^AW
//   Done                instruction-complete strobe from the core
//   DIN, Run            instruction/immediate word and issue strobe to the core
//   PC                  address of the current instruction
//   Busy/Halted/Error   status decoded from the state register
module proc_feeder #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          LdEn,
  input  logic [AW-1:0] LdAddr,
  input  logic [15:0]   LdData,
  input  logic [AW:0]   ProgLen,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW:0]   PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Error
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [AW:0]    pc_q, pc_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [15:0]    mem_q [2**AW];

  logic [AW-1:0]  rd_addr;
  logic [AW-1:0]  imm_addr;
  logic [15:0]    cur_word;
  logic [15:0]    imm_word;
  logic [AW:0]    pc_step;
  logic [AW:0]    pc_next;
  logic [WDW-1:0] wd_inc;
  logic           load_ok;

  // The immediate address wraps inside the memory, so an mvi in the last
  // word takes its operand from address 0.
  assign rd_addr  = pc_q[AW-1:0];
  assign imm_addr = rd_addr + AW'(1);
  assign cur_word = mem_q[rd_addr];
  assign imm_word = mem_q[imm_addr];

  assign pc_step  = (cur_word[15:13] == 3'b001) ? (AW+1)'(2) : (AW+1)'(1);
  assign pc_next  = pc_q + pc_step;
  assign wd_inc   = wd_q + WDW'(1);

  assign load_ok  = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR);

  always_ff @(posedge Clock) begin
    if (LdEn && load_ok) begin
      mem_q[LdAddr] <= LdData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (Start) begin
          pc_d    = '0;
          state_d = (ProgLen == '0) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Done seen while issuing belongs to nothing we issued; ignore it.
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        // Done takes priority over the watchdog expiring in the same cycle.
        if (Done) begin
          pc_d    = pc_next;
          state_d = (pc_next >= ProgLen) ? S_HALT : S_ISSUE;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WDW'(TIMEOUT)) begin
            state_d = S_ERR;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    DIN = 16'h0000;
    case (state_q)
      S_ISSUE: DIN = cur_word;
      S_WAIT:  DIN = imm_word;
      default: DIN = 16'h0000;
    endcase
  end

  assign Run    = (state_q == S_ISSUE);
  assign Busy   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign Halted = (state_q == S_HALT);
  assign Error  = (state_q == S_ERR);
  assign PC     = pc_q;

endmodule

// File: tb/tb_proc_feeder.sv
// tb/tb_proc_feeder.sv - self-checking bench for proc_feeder
module tb_proc_feeder;

  localparam int AW      = 5;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 32;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic          ld_en    = 1'b0;
  logic [AW-1:0] ld_addr  = '0;
  logic [15:0]   ld_data  = '0;
  logic [AW:0]   prog_len = '0;
  logic          core_done = 1'b0;
  logic [15:0]   din;
  logic          run;
  logic [AW:0]   pc;
  logic          busy, halted, error;

  logic          start2    = 1'b0;
  logic          ld_en2    = 1'b0;
  logic [1:0]    ld_addr2  = '0;
  logic [15:0]   ld_data2  = '0;
  logic [2:0]    prog_len2 = '0;
  logic          done2     = 1'b0;
  logic [15:0]   din2;
  logic          run2;
  logic [2:0]    pc2;
  logic          busy2, halted2, error2;

  int n_pass  = 0;
  int n_total = 0;

  proc_feeder #(.AW(AW), .TIMEOUT(TIMEOUT)) u_dut (
    .Clock(clk), .Reset(rst), .Start(start), .LdEn(ld_en), .LdAddr(ld_addr),
    .LdData(ld_data), .ProgLen(prog_len), .Done(core_done), .DIN(din), .Run(run),
    .PC(pc), .Busy(busy), .Halted(halted), .Error(error)
  );

  proc_feeder #(.AW(2), .TIMEOUT(TIMEOUT)) u_dut2 (
    .Clock(clk), .Reset(rst), .Start(start2), .LdEn(ld_en2), .LdAddr(ld_addr2),
    .LdData(ld_data2), .ProgLen(prog_len2), .Done(done2), .DIN(din2), .Run(run2),
    .PC(pc2), .Busy(busy2), .Halted(halted2), .Error(error2)
  );

  always #5 clk = ~clk;

  // Toy core: 4 registers, X=[10:9], Y=[8:7]. mode 0 = real latencies,
  // 1 = Done one cycle after Run, 2 = never answers.
  int          core_mode = 0;
  int          rem = 0;
  int          cyc = 0;
  logic [15:0] ir = '0;
  logic [15:0] r [4];

  int          rec_pc  [$];
  logic [15:0] rec_din [$];
  logic [15:0] rec_imm [$];
  int          rec_cyc [$];

  logic [15:0] prog [DEPTH];
  int          exp_pcs [$];
  int          exp_final;

  function automatic int core_lat(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b110, 3'b111: return 1;
      3'b100, 3'b101:                 return 2;
      default:                        return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rem       = 0;
      core_done = 1'b0;
    end else begin
      core_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          core_done = 1'b1;
          rec_imm.push_back(din);
          case (ir[15:13])
            3'b000: r[ir[10:9]] = r[ir[8:7]];
            3'b001: r[ir[10:9]] = din;
            3'b010: r[ir[10:9]] = r[ir[10:9]] + r[ir[8:7]];
            3'b011: r[ir[10:9]] = r[ir[10:9]] - r[ir[8:7]];
            default: ;
          endcase
        end
      end else if (run) begin
        rec_pc.push_back(int'(pc));
        rec_din.push_back(din);
        rec_cyc.push_back(cyc);
        ir = din;
        if (core_mode != 2) rem = (core_mode == 1) ? 1 : core_lat(din[15:13]);
      end
    end
  end

  // Reference: walk the program by word counts alone.
  function automatic void model_run(input int len);
    int p = 0;
    exp_pcs.delete();
    while (p < len) begin
      exp_pcs.push_back(p);
      p += (prog[p % DEPTH][15:13] == 3'b001) ? 2 : 1;
    end
    exp_final = p;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    rec_pc.delete(); rec_din.delete(); rec_imm.delete(); rec_cyc.delete();
    for (int i = 0; i < 4; i++) r[i] = '0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = prog[i];
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_prog(input int len, input int mode, output bit ok);
    clear_rec();
    prog_len  = (AW+1)'(len);
    core_mode = mode;
    pulse_start();
    for (int i = 0; i < 400 && !halted && !error; i++) tick();
    ok = halted;
  endtask

  task automatic load_basic();
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = 16'h2000; prog[1] = 16'h0005; prog[2] = 16'h0200; prog[3] = 16'h4080;
    load_prog();
  endtask

  task automatic test_reset();
    n_total++; if (run !== 1'b0) $display("FAIL reset_run got=%b exp=0", run); else n_pass++;
    n_total++; if (din !== 16'h0) $display("FAIL reset_din got=%h exp=0000", din); else n_pass++;
    n_total++; if (pc !== '0) $display("FAIL reset_pc got=%0d exp=0", pc); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL reset_error got=%b exp=0", error); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    load_basic();
    run_prog(4, 0, ok);
    n_total++; if (!ok) $display("FAIL basic_halt got=%b exp=1", halted); else n_pass++;
    n_total++; if (rec_pc.size() != 3) $display("FAIL basic_runs got=%0d exp=3", rec_pc.size()); else n_pass++;
    n_total++;
    if (rec_imm.size() == 0 || rec_imm[0] !== 16'h0005)
      $display("FAIL basic_imm got=%h exp=0005", (rec_imm.size() == 0) ? 16'hxxxx : rec_imm[0]);
    else n_pass++;
    n_total++; if (r[0] !== 16'd10) $display("FAIL basic_r0 got=%0d exp=10", r[0]); else n_pass++;
    n_total++; if (pc !== 6'd4) $display("FAIL basic_pc got=%0d exp=4", pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
    load_prog();
    model_run(14);
    run_prog(14, 1, ok);
    n_total++; if (!ok) $display("FAIL b2b_halt got=%b exp=1", halted); else n_pass++;
    n_total++;
    if (rec_cyc.size() != exp_pcs.size()) $display("FAIL b2b_runs got=%0d exp=%0d", rec_cyc.size(), exp_pcs.size());
    else n_pass++;
    for (int i = 1; i < rec_cyc.size(); i++) begin
      n_total++;
      if (rec_cyc[i] - rec_cyc[i-1] != 2) $display("FAIL b2b_gap idx=%0d got=%0d exp=2", i, rec_cyc[i] - rec_cyc[i-1]);
      else n_pass++;
    end
    n_total++; if (int'(pc) != exp_final) $display("FAIL b2b_pc got=%0d exp=%0d", pc, exp_final); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int len, mode;
    for (int t = 0; t < 6; t++) begin
      len  = $urandom_range(1, DEPTH);
      mode = $urandom_range(0, 1);
      for (int i = 0; i < DEPTH; i++) begin
        prog[i] = 16'($urandom);
        if ($urandom_range(0, 2) == 0) prog[i][15:13] = 3'b001;
      end
      load_prog();
      model_run(len);
      run_prog(len, mode, ok);
      n_total++; if (!ok) $display("FAIL rnd_halt t=%0d got=%b exp=1", t, halted); else n_pass++;
      n_total++;
      if (rec_pc.size() != exp_pcs.size()) $display("FAIL rnd_runs t=%0d got=%0d exp=%0d", t, rec_pc.size(), exp_pcs.size());
      else n_pass++;
      for (int i = 0; i < exp_pcs.size() && i < rec_pc.size(); i++) begin
        n_total++;
        if (rec_pc[i] != exp_pcs[i]) $display("FAIL rnd_pc t=%0d i=%0d got=%0d exp=%0d", t, i, rec_pc[i], exp_pcs[i]);
        else n_pass++;
        n_total++;
        if (rec_din[i] !== prog[exp_pcs[i] % DEPTH])
          $display("FAIL rnd_din t=%0d i=%0d got=%h exp=%h", t, i, rec_din[i], prog[exp_pcs[i] % DEPTH]);
        else n_pass++;
        if (i < rec_imm.size()) begin
          n_total++;
          if (rec_imm[i] !== prog[(exp_pcs[i] + 1) % DEPTH])
            $display("FAIL rnd_imm t=%0d i=%0d got=%h exp=%h", t, i, rec_imm[i], prog[(exp_pcs[i] + 1) % DEPTH]);
          else n_pass++;
        end
      end
      n_total++; if (int'(pc) != exp_final) $display("FAIL rnd_final t=%0d got=%0d exp=%0d", t, pc, exp_final); else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    int err_cyc = -1;
    load_basic();
    clear_rec();
    prog_len  = 6'd4;
    core_mode = 2;
    pulse_start();
    for (int i = 0; i < 60 && err_cyc < 0; i++) begin
      if (error) err_cyc = cyc;
      else tick();
    end
    n_total++; if (err_cyc < 0) $display("FAIL wd_timeout got=no_error exp=error"); else n_pass++;
    n_total++;
    if (rec_cyc.size() == 0 || err_cyc - rec_cyc[0] != TIMEOUT + 1)
      $display("FAIL wd_latency got=%0d exp=%0d", (rec_cyc.size() == 0) ? -1 : err_cyc - rec_cyc[0], TIMEOUT + 1);
    else n_pass++;
    n_total++; if (pc !== 6'd0) $display("FAIL wd_pc got=%0d exp=0", pc); else n_pass++;
    n_total++; if (din !== 16'h0) $display("FAIL wd_din got=%h exp=0000", din); else n_pass++;
    core_mode = 0;
    clear_rec();
    pulse_start();
    n_total++; if (error !== 1'b0) $display("FAIL wd_clear got=%b exp=0", error); else n_pass++;
    n_total++; if (run !== 1'b1 || pc !== 6'd0 || din !== 16'h2000)
      $display("FAIL wd_reissue got=run%b/pc%0d/%h exp=run1/pc0/2000", run, pc, din);
    else n_pass++;
    for (int i = 0; i < 60 && !halted; i++) tick();
    n_total++; if (r[0] !== 16'd10) $display("FAIL wd_rerun_r0 got=%0d exp=10", r[0]); else n_pass++;
  endtask

  task automatic test_zero_len();
    clear_rec();
    prog_len  = '0;
    core_mode = 0;
    pulse_start();
    n_total++; if (halted !== 1'b1) $display("FAIL zero_halted got=%b exp=1", halted); else n_pass++;
    repeat (4) tick();
    n_total++; if (rec_pc.size() != 0) $display("FAIL zero_runs got=%0d exp=0", rec_pc.size()); else n_pass++;
    n_total++; if (pc !== 6'd0) $display("FAIL zero_pc got=%0d exp=0", pc); else n_pass++;
  endtask

  task automatic test_load_guard();
    load_basic();
    clear_rec();
    prog_len  = 6'd4;
    core_mode = 2;
    pulse_start();
    tick();
    ld_en = 1'b1; ld_addr = '0; ld_data = 16'hFFFF;
    tick();
    ld_en = 1'b0;
    for (int i = 0; i < 60 && !error; i++) tick();
    n_total++; if (error !== 1'b1) $display("FAIL guard_err got=%b exp=1", error); else n_pass++;
    core_mode = 0;
    clear_rec();
    pulse_start();
    n_total++; if (din !== 16'h2000) $display("FAIL guard_word got=%h exp=2000", din); else n_pass++;
    for (int i = 0; i < 60 && !halted; i++) tick();
    n_total++; if (r[0] !== 16'd10) $display("FAIL guard_r0 got=%0d exp=10", r[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    clear_rec();
    prog_len  = 6'd4;
    core_mode = 2;
    pulse_start();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_reset();
    run_prog(4, 0, ok);
    n_total++; if (!ok) $display("FAIL rstw_halt got=%b exp=1", halted); else n_pass++;
    n_total++; if (rec_pc.size() != 3) $display("FAIL rstw_runs got=%0d exp=3", rec_pc.size()); else n_pass++;
    n_total++; if (r[0] !== 16'd10) $display("FAIL rstw_r0 got=%0d exp=10", r[0]); else n_pass++;
    n_total++; if (pc !== 6'd4) $display("FAIL rstw_pc got=%0d exp=4", pc); else n_pass++;
  endtask

  task automatic test_wrap_aw2();
    logic [15:0] mem2 [4];
    logic [15:0] last_imm = '0;
    int runs = 0;
    mem2[0] = 16'hABCD; mem2[1] = 16'h0000; mem2[2] = 16'h0600; mem2[3] = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      ld_en2 = 1'b1; ld_addr2 = 2'(i); ld_data2 = mem2[i];
      tick();
    end
    ld_en2    = 1'b0;
    prog_len2 = 3'd4;
    start2    = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 100 && !halted2; i++) begin
      if (run2) runs++;
      done2 = busy2 && !run2;
      if (done2) last_imm = din2;
      tick();
    end
    done2 = 1'b0;
    n_total++; if (halted2 !== 1'b1) $display("FAIL wrap_halt got=%b exp=1", halted2); else n_pass++;
    n_total++; if (runs != 4) $display("FAIL wrap_runs got=%0d exp=4", runs); else n_pass++;
    n_total++; if (last_imm !== 16'hABCD) $display("FAIL wrap_imm got=%h exp=abcd", last_imm); else n_pass++;
    n_total++; if (pc2 !== 3'd5) $display("FAIL wrap_pc got=%0d exp=5", pc2); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) r[i] = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_watchdog();
    test_zero_len();
    test_load_guard();
    test_reset_mid_wait();
    test_wrap_aw2();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
